// File: rtl/alu_mb_seq.sv
// Multi-byte sequencer that drives an external 8-bit ALU one byte per cycle,
// LSB first, chaining carry/borrow to build 8..32-bit results.
module alu_mb_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [1:0]  len,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carry_in,
  output logic [7:0]  alu_in1,
  output logic [7:0]  alu_in2,
  output logic [2:0]  opcode,
  output logic        cin,
  input  logic [7:0]  alu_out,
  input  logic        cout,
  output logic [31:0] result,
  output logic        carry,
  output logic        zero,
  output logic        busy,
  output logic        done
);

  // Function codes shared with the Alu.
  localparam logic [2:0] ADD_FN  = 3'd0;
  localparam logic [2:0] ADDC_FN = 3'd1;
  localparam logic [2:0] SUB_FN  = 3'd2;
  localparam logic [2:0] SUBC_FN = 3'd3;
  localparam logic [2:0] AND_FN  = 3'd4;
  localparam logic [2:0] OR_FN   = 3'd5;
  localparam logic [2:0] XOR_FN  = 3'd6;
  localparam logic [2:0] MASK_FN = 3'd7;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  op_q;
  logic [1:0]  len_q;
  logic        carry_in_q;
  logic [1:0]  idx_q;
  logic        c_q;
  logic [31:0] result_q;
  logic        carry_q;
  logic        zero_q;

  logic        is_arith;
  logic        is_add;
  logic [4:0]  bit_base;
  logic [31:0] result_nxt;

  assign is_add   = (op_q == ADD_FN) || (op_q == ADDC_FN);
  assign is_arith = is_add || (op_q == SUB_FN) || (op_q == SUBC_FN);
  assign bit_base = {idx_q, 3'b000};

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    alu_in1 = 8'h00;
    alu_in2 = 8'h00;
    opcode  = ADD_FN;
    cin     = 1'b0;
    if (state_q == RUN) begin
      alu_in1 = a_q[bit_base +: 8];
      alu_in2 = b_q[bit_base +: 8];
      if (!is_arith) begin
        opcode = op_q;
      end else if (idx_q == 2'd0) begin
        opcode = op_q;
        cin    = ((op_q == ADDC_FN) || (op_q == SUBC_FN)) ? carry_in_q : 1'b0;
      end else begin
        // Upper bytes always consume the chained carry/borrow.
        opcode = is_add ? ADDC_FN : SUBC_FN;
        cin    = c_q;
      end
    end
  end

  always_comb begin
    result_nxt = result_q;
    result_nxt[bit_base +: 8] = alu_out;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= ADD_FN;
      len_q      <= '0;
      carry_in_q <= 1'b0;
      idx_q      <= '0;
      c_q        <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q        <= a;
            b_q        <= b;
            op_q       <= op;
            len_q      <= len;
            carry_in_q <= carry_in;
            idx_q      <= '0;
            c_q        <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          result_q <= result_nxt;
          // The Alu leaves cout stale on logic ops, so never sample it then.
          if (is_arith) begin
            c_q <= cout;
          end
          idx_q <= idx_q + 2'd1;
          if (idx_q == len_q) begin
            carry_q <= is_arith ? cout : 1'b0;
            zero_q  <= (result_nxt == 32'h0);
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);

endmodule
